mdu_iter: RTL

Parametrised multi-cycle multiply/divide unit for the Execute stage of the five-stage MIPS pipeline. It owns the HI/LO registers, runs mult/multu/div/divu (and optionally madd/msub) over a configurable number of cycles, and exports `busy` so the hazard unit can stall MDU instructions in Decode while an operation is in flight. It generalises the fixed-width, fixed-latency MDU with width, per-class latency and accumulate modes.

---
 rtl/mdu_iter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mdu_iter.sv
// Multi-cycle multiply/divide unit owning HI/LO for the Execute stage.
// Optional accumulate ops (madd/maddu/msub/msubu) are built when MDU_MADD_EN is defined.
module mdu_iter #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mt_we,
  input  logic             mt_sel,
  input  logic [WIDTH-1:0] mt_data,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [2:0] OP_DIV  = 3'd2;
  localparam logic [2:0] OP_DIVU = 3'd3;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [0:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;

  logic               op_ok;
  logic               is_signed;
  logic [2*WIDTH-1:0] a_ext, b_ext, product;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, b_div, q_mag, r_mag, quot, rem;
  logic [2*WIDTH-1:0] div_res, result;

`ifdef MDU_MADD_EN
  assign op_ok = 1'b1;
`else
  assign op_ok = ~op[2];
`endif

  // Even op codes in each group (mult, div, madd, msub) are the signed variants.
  assign is_signed = ~op_q[0];

  assign a_ext   = {{WIDTH{is_signed & a_q[WIDTH-1]}}, a_q};
  assign b_ext   = {{WIDTH{is_signed & b_q[WIDTH-1]}}, b_q};
  assign product = a_ext * b_ext;

  // Divide on magnitudes, then restore signs; min / -1 wraps back to min with remainder 0.
  assign a_neg   = is_signed & a_q[WIDTH-1];
  assign b_neg   = is_signed & b_q[WIDTH-1];
  assign a_mag   = a_neg ? -a_q : a_q;
  assign b_mag   = b_neg ? -b_q : b_q;
  assign b_div   = (b_q == '0) ? ONE : b_mag;
  assign q_mag   = a_mag / b_div;
  assign r_mag   = a_mag % b_div;
  assign quot    = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem     = a_neg ? -r_mag : r_mag;
  assign div_res = (b_q == '0) ? {a_q, {WIDTH{1'b1}}} : {rem, quot};

  // NOTE: every signal assigned in a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    result = product;
    case (op_q)
      OP_DIV, OP_DIVU: result = div_res;
`ifdef MDU_MADD_EN
      3'd4, 3'd5:      result = {hi_q, lo_q} + product;
      3'd6, 3'd7:      result = {hi_q, lo_q} - product;
`endif
      default:         result = product;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (start && op_ok) begin
          op_d    = op;
          a_d     = rs_val;
          b_d     = rt_val;
          cnt_d   = (op[2:1] == 2'b01) ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
          state_d = S_RUN;
          busy_d  = 1'b1;
        end else if (mt_we && !start) begin
          if (mt_sel) hi_d = mt_data;
          else        lo_d = mt_data;
        end
      end
      S_RUN: begin
        if (cnt_q == CW'(1)) begin
          {hi_d, lo_d} = result;
          cnt_d        = '0;
          state_d      = S_IDLE;
          busy_d       = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
